// File: rtl/store_write_buffer_if.sv
// Store-side bus between the MEM stage / data memory and the store write buffer.
// The buffer uses the slave modport, and the pipeline/memory side uses the master modport.
interface store_write_buffer_if;
  logic        st_valid;
  logic [1:0]  st_op;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_ready;
  logic        st_ades;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] ld_addr;
  logic        ld_hit;

  modport master (
    output st_valid, st_op, st_addr, st_data, mem_ready, ld_addr,
    input  st_ready, st_ades, mem_valid, mem_addr, mem_wdata, mem_be, ld_hit
  );

  modport slave (
    input  st_valid, st_op, st_addr, st_data, mem_ready, ld_addr,
    output st_ready, st_ades, mem_valid, mem_addr, mem_wdata, mem_be, ld_hit
  );
endinterface

// File: rtl/store_write_buffer.sv
// Store write buffer: aligns sw/sh/sb stores into word writes with byte enables,
// queues them in a small FIFO, drains them to data memory, and flags load hazards.
module store_write_buffer #(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  store_write_buffer_if.slave      bus,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_SW   = 2'b01,
    OP_SH   = 2'b10,
    OP_SB   = 2'b11
  } st_op_e;

  st_op_e        op;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_next;
  logic [31:0]   addr_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [3:0]    be_q   [DEPTH];
  logic [31:0]   new_addr;
  logic [31:0]   new_wdata;
  logic [3:0]    new_be;
  logic          push;
  logic          pop;
  logic [CW-1:0] count_after_pop;
  logic          head_is_new;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign op = st_op_e'(bus.st_op);

  always_comb begin
    bus.st_ades = 1'b0;
    if (bus.st_valid) begin
      unique case (op)
        OP_SW:   bus.st_ades = (bus.st_addr[1:0] != 2'b00);
        OP_SH:   bus.st_ades = bus.st_addr[0];
        default: bus.st_ades = 1'b0;
      endcase
    end
  end

  always_comb begin
    new_addr  = {bus.st_addr[31:2], 2'b00};
    new_wdata = bus.st_data;
    new_be    = 4'b1111;
    unique case (op)
      OP_SH: begin
        new_wdata = {bus.st_data[15:0], bus.st_data[15:0]};
        new_be    = bus.st_addr[1] ? 4'b1100 : 4'b0011;
      end
      OP_SB: begin
        new_wdata = {4{bus.st_data[7:0]}};
        new_be    = 4'b0001 << bus.st_addr[1:0];
      end
      default: begin
        new_wdata = bus.st_data;
        new_be    = 4'b1111;
      end
    endcase
  end

  assign bus.st_ready  = (count != CW'(DEPTH));
  assign bus.mem_valid = (count != '0);

  assign push = bus.st_valid & bus.st_ready & (op != OP_NONE) & ~bus.st_ades;
  assign pop  = bus.mem_valid & bus.mem_ready;

  assign rd_next         = pop ? ptr_inc(rd_ptr) : rd_ptr;
  assign count_after_pop = count - CW'(pop);
  // A push into a buffer that is empty after this cycle's pop becomes the head directly.
  assign head_is_new     = push && (count_after_pop == '0);

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr] <= new_addr;
      data_q[wr_ptr] <= new_wdata;
      be_q[wr_ptr]   <= new_be;
    end
  end

  // mem_* is registered and only reloaded while an entry remains, so it holds when empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_be    <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      rd_ptr <= rd_next;
      count  <= count_after_pop + CW'(push);
      if (head_is_new) begin
        bus.mem_addr  <= new_addr;
        bus.mem_wdata <= new_wdata;
        bus.mem_be    <= new_be;
      end else if (count_after_pop != '0) begin
        bus.mem_addr  <= addr_q[rd_next];
        bus.mem_wdata <= data_q[rd_next];
        bus.mem_be    <= be_q[rd_next];
      end
    end
  end

  always_comb begin
    logic [PW-1:0] offs;
    offs        = '0;
    bus.ld_hit  = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      offs = PW'(i) - rd_ptr;
      if ((CW'(offs) < count) && (addr_q[i] == (bus.ld_addr & 32'hFFFF_FFFC)))
        bus.ld_hit = 1'b1;
    end
  end

endmodule

// File: tb/tb_store_write_buffer.sv
// Directed self-checking bench for store_write_buffer with DEPTH=2.
module tb_store_write_buffer;
  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] count;
  int         total = 0;
  int         bad = 0;

  store_write_buffer_if sif();

  store_write_buffer #(.DEPTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sif),
    .count (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
    sif.st_valid = v;
    sif.st_op    = op;
    sif.st_addr  = a;
    sif.st_data  = d;
  endtask

  task automatic chk_head(input string tag, input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    chk({tag, "_valid"}, {31'b0, sif.mem_valid}, 32'd1);
    chk({tag, "_addr"}, sif.mem_addr, a);
    chk({tag, "_be"}, {28'b0, sif.mem_be}, {28'b0, be});
    chk({tag, "_wdata"}, sif.mem_wdata, d);
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    sif.mem_ready = 1'b0;
    sif.ld_addr   = 32'h0;
    step();
    step();
    reset = 1'b0;
    chk("rst_count", {30'b0, count}, 32'd0);
    chk("rst_mem_valid", {31'b0, sif.mem_valid}, 32'd0);
    chk("rst_st_ready", {31'b0, sif.st_ready}, 32'd1);
    chk("rst_ld_hit", {31'b0, sif.ld_hit}, 32'd0);
    chk("rst_mem_addr", sif.mem_addr, 32'h0);
    chk("rst_mem_wdata", sif.mem_wdata, 32'h0);
    chk("rst_mem_be", {28'b0, sif.mem_be}, 32'h0);

    // Aligned stores streaming with mem_ready high.
    sif.mem_ready = 1'b1;
    drive(1'b1, 2'b01, 32'h0000_1004, 32'hDEAD_BEEF);
    #1 chk("sw_ades", {31'b0, sif.st_ades}, 32'd0);
    step();
    chk_head("sw", 32'h1004, 4'b1111, 32'hDEAD_BEEF);
    chk("sw_count", {30'b0, count}, 32'd1);
    drive(1'b1, 2'b10, 32'h0000_100A, 32'h1234_ABCD);
    step();
    chk_head("sh_hi", 32'h1008, 4'b1100, 32'hABCD_ABCD);
    chk("sh_count", {30'b0, count}, 32'd1);
    drive(1'b1, 2'b11, 32'h0000_1003, 32'h0000_00FF);
    step();
    chk_head("sb3", 32'h1000, 4'b1000, 32'hFFFF_FFFF);
    drive(1'b1, 2'b11, 32'h0000_1001, 32'h1234_5677);
    step();
    chk_head("sb1", 32'h1000, 4'b0010, 32'h7777_7777);
    drive(1'b1, 2'b10, 32'h0000_2010, 32'h0000_5678);
    step();
    chk_head("sh_lo", 32'h2010, 4'b0011, 32'h5678_5678);
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    step();
    chk("drain_valid", {31'b0, sif.mem_valid}, 32'd0);
    chk("drain_count", {30'b0, count}, 32'd0);
    chk("hold_addr", sif.mem_addr, 32'h2010);
    chk("hold_be", {28'b0, sif.mem_be}, 32'h3);

    // Misaligned requests and st_op 00 are dropped.
    drive(1'b1, 2'b01, 32'h0000_1002, 32'h1111_1111);
    #1 chk("sw_mis_ades", {31'b0, sif.st_ades}, 32'd1);
    step();
    chk("sw_mis_count", {30'b0, count}, 32'd0);
    chk("sw_mis_valid", {31'b0, sif.mem_valid}, 32'd0);
    drive(1'b1, 2'b10, 32'h0000_1001, 32'h2222_2222);
    #1 chk("sh_mis_ades", {31'b0, sif.st_ades}, 32'd1);
    step();
    chk("sh_mis_count", {30'b0, count}, 32'd0);
    drive(1'b1, 2'b00, 32'h0000_1003, 32'h3333_3333);
    #1 chk("nop_ades", {31'b0, sif.st_ades}, 32'd0);
    step();
    chk("nop_count", {30'b0, count}, 32'd0);
    chk("nop_valid", {31'b0, sif.mem_valid}, 32'd0);
    drive(1'b0, 2'b01, 32'h0000_1002, 32'h0);
    #1 chk("novalid_ades", {31'b0, sif.st_ades}, 32'd0);

    // Fill, full stall, simultaneous push/pop while full, drain with wrap.
    sif.mem_ready = 1'b0;
    drive(1'b1, 2'b01, 32'h0000_4000, 32'h0000_0001);
    step();
    drive(1'b1, 2'b01, 32'h0000_4004, 32'h0000_0002);
    step();
    chk("full_count", {30'b0, count}, 32'd2);
    chk("full_ready", {31'b0, sif.st_ready}, 32'd0);
    chk_head("full_head", 32'h4000, 4'b1111, 32'h1);
    drive(1'b1, 2'b01, 32'h0000_4008, 32'h0000_0003);
    step();
    chk("full_ignore", {30'b0, count}, 32'd2);
    chk("full_stable", sif.mem_addr, 32'h4000);
    drive(1'b1, 2'b01, 32'h0000_400C, 32'h0000_0004);
    sif.mem_ready = 1'b1;
    step();
    chk("nobypass_count", {30'b0, count}, 32'd1);
    chk_head("second", 32'h4004, 4'b1111, 32'h2);
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    step();
    chk("fill_drain_count", {30'b0, count}, 32'd0);
    chk("fill_drain_valid", {31'b0, sif.mem_valid}, 32'd0);
    chk("fill_hold", sif.mem_addr, 32'h4004);

    // Load hazard against a pending store.
    sif.mem_ready = 1'b0;
    sif.ld_addr   = 32'h0000_2000;
    drive(1'b1, 2'b01, 32'h0000_2000, 32'h0000_000A);
    #1 chk("hit_same_cycle", {31'b0, sif.ld_hit}, 32'd0);
    step();
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    sif.ld_addr = 32'h0000_2003;
    #1 chk("hit_2003", {31'b0, sif.ld_hit}, 32'd1);
    sif.ld_addr = 32'h0000_2004;
    #1 chk("hit_2004", {31'b0, sif.ld_hit}, 32'd0);
    sif.mem_ready = 1'b1;
    step();
    sif.mem_ready = 1'b0;
    sif.ld_addr   = 32'h0000_2003;
    #1 chk("hit_after_pop", {31'b0, sif.ld_hit}, 32'd0);

    // Reset mid-operation with a simultaneous push and pop.
    drive(1'b1, 2'b01, 32'h0000_5000, 32'h0000_0050);
    step();
    drive(1'b1, 2'b01, 32'h0000_5004, 32'h0000_0054);
    step();
    chk("pre_rst_count", {30'b0, count}, 32'd2);
    reset = 1'b1;
    sif.mem_ready = 1'b1;
    drive(1'b1, 2'b11, 32'h0000_5008, 32'h0000_0058);
    step();
    reset = 1'b0;
    sif.mem_ready = 1'b0;
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    chk("mid_rst_count", {30'b0, count}, 32'd0);
    chk("mid_rst_valid", {31'b0, sif.mem_valid}, 32'd0);
    chk("mid_rst_be", {28'b0, sif.mem_be}, 32'h0);
    chk("mid_rst_ready", {31'b0, sif.st_ready}, 32'd1);
    chk("mid_rst_addr", sif.mem_addr, 32'h0);
    step();
    chk("post_rst_idle", {31'b0, sif.mem_valid}, 32'd0);
    drive(1'b1, 2'b01, 32'h0000_3000, 32'h0000_0033);
    step();
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    chk_head("post_rst", 32'h3000, 4'b1111, 32'h33);
    chk("post_rst_count", {30'b0, count}, 32'd1);
    sif.mem_ready = 1'b1;
    step();
    chk("post_rst_drained", {31'b0, sif.mem_valid}, 32'd0);
    chk("post_rst_count0", {30'b0, count}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/store_write_buffer.md
# store_write_buffer

- Write-side counterpart of the load extension path: takes a store (sw/sh/sb) from the MEM stage and produces the word-aligned address, lane-replicated write data and 4-bit byte enables the data memory needs.
- Holds accepted stores in a small FIFO and drains them to data memory over a valid/ready handshake.
- Stalls the pipeline when the FIFO is full.
- Flags loads that hit a still-pending store to the same word, and flags misaligned stores as AdES.

## Interface
Parameters:
- DEPTH, 2: FIFO entries; legal values 2 or 4.

Ports (clock and reset first):
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- st_valid  in  1  MEM stage presents a store this cycle.
- st_op  in  2  store width, same encoding as the load-side select: 01 sw, 10 sh, 11 sb, 00 no store.
- st_addr  in  32  byte address of the store.
- st_data  in  32  unshifted rt value.
- st_ready  out  1  buffer can accept; equals (count != DEPTH).
- st_ades  out  1  combinational: st_valid high and address misaligned for st_op.
- mem_valid  out  1  head entry valid; equals (count != 0).
- mem_ready  in  1  data memory accepts head entry this cycle.
- mem_addr  out  32  head word address; bits [1:0] always 0.
- mem_wdata  out  32  head write data, lane-replicated.
- mem_be  out  4  head byte enables; bit i enables byte lane i, bits [8i+7:8i].
- ld_addr  in  32  address of the load in the MEM stage.
- ld_hit  out  1  combinational: a buffered entry has the same word address as ld_addr.
- count  out  log2(DEPTH)+1  number of occupied entries.

## Operation
Misalignment:
- sw is misaligned when addr[1:0] != 0.
- sh is misaligned when addr[0] != 0.
- sb is never misaligned.
- st_op 00 never raises st_ades.

Push:
- Condition: st_valid & st_ready & (st_op != 00) & !st_ades.
- A misaligned or 00 request is dropped: no push, no state change.

Entry formation at push:
- addr = {st_addr[31:2], 2'b00}.
- sw: be = 1111, wdata = st_data.
- sh: be = 0011 when addr[1]=0, else 1100; wdata = {st_data[15:0], st_data[15:0]}.
- sb: be = 0001 << addr[1:0]; wdata = {4{st_data[7:0]}}.

Pop:
- Condition: mem_valid & mem_ready.
- Head pointer advances; the next entry appears on mem_* the following cycle.

FIFO:
- Circular buffer with rd_ptr and wr_ptr of log2(DEPTH) bits each; pointers wrap from DEPTH-1 to 0.
- Push and pop in the same cycle leave count unchanged.
- Full: count == DEPTH, st_ready = 0. No bypass; a pop in the same cycle does not make room for a push that cycle.
- Empty: mem_valid = 0. A push does not reach mem_* in the same cycle.

Outputs while empty:
- mem_addr, mem_wdata and mem_be hold the last value driven.
- The memory must ignore them because mem_valid = 0.

ld_hit:
- Compares ld_addr[31:2] against every occupied entry.
- An entry pushed in the current cycle is not yet included.
- The pipeline stalls the load while ld_hit = 1.

## Timing
Reset values:
- count 0, mem_valid 0, st_ready 1, ld_hit 0.
- mem_addr 0, mem_wdata 0, mem_be 0000.
- rd_ptr 0, wr_ptr 0.

Reset mid-operation:
- All buffered stores are discarded; no further mem_valid.
- Reset has priority over simultaneous push and pop.

Latency:
- A store pushed at edge N is on mem_* with mem_valid=1 from cycle N+1, when the buffer was empty.
- Otherwise it appears after the entries ahead of it drain.

Throughput: one push and one pop per cycle.

Handshake:
- mem_* remain stable while mem_valid=1 and mem_ready=0.
- mem_ready has no effect when mem_valid=0.

Combinational paths:
- st_ades depends on st_valid, st_op and st_addr only.
- ld_hit depends on ld_addr and registered state only.

## Test plan
- Aligned stores: after reset, push sw 0x0000_1004 data 0xDEADBEEF, then sh 0x0000_100A data 0x1234_ABCD, then sb 0x0000_1003 data 0xFF, with mem_ready=1. Required mem sequence:
  - addr 0x1004, be 1111, wdata 0xDEADBEEF
  - addr 0x1008, be 1100, wdata 0xABCDABCD
  - addr 0x1000, be 1000, wdata 0xFFFFFFFF
  - one entry per cycle, each starting the cycle after its push.
- Misaligned stores: sw at 0x1002 and sh at 0x1001 → st_ades=1 in each request cycle, count stays 0, mem_valid stays 0.
- Fill and drain: hold mem_ready=0 and push DEPTH stores → st_ready=0 and further pushes ignored. Then push and assert mem_ready=1 in the same cycle → count drops to DEPTH-1, no push taken. Drain fully with pointer wrap; entries leave in FIFO order.
- Load hazard: buffer a sw to 0x2000 with mem_ready=0.
  - ld_addr 0x2003 → ld_hit=1.
  - ld_addr 0x2004 → ld_hit=0.
  - after the pop → ld_hit=0 for 0x2003.
- Reset mid-operation: 2 entries buffered, then reset for 1 cycle → next cycle count 0, mem_valid 0, mem_be 0000, st_ready 1. A following push to 0x3000 is the only write that emerges.
